// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the FPU request arbiter: FSM state encoding,
// FPU op-select codes and the operand/result word width.
package fpu_arb_pkg;
  localparam int WORD_W = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;
endpackage

// File: rtl/fpu_req_arbiter_rr_pick.sv
// rr_pick: combinational winner finder. Searches i_valid upward from i_ptr,
// wrapping NREQ-1 -> 0, and returns the first set index.
//   i_valid  : request vector
//   i_ptr    : search start index (0 gives fixed lowest-index priority)
//   o_onehot : winner as a one-hot vector (all zero if nothing valid)
//   o_idx    : winner index
//   o_any    : at least one request valid
module rr_pick #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [GW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [GW-1:0]   o_idx,
  output logic            o_any
);
  int w_j;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!o_any && i_valid[w_j]) begin
        o_any         = 1'b1;
        o_onehot[w_j] = 1'b1;
        o_idx         = GW'(w_j);
      end
    end
  end
endmodule

// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: shares one FPU among NREQ requesters, one op in flight.
// Flow: IDLE (accept winner, latch operands) -> ISSUE (fpu_start pulse)
//       -> CAPTURE (latch FPU result) -> RESP (hold resp_valid until taken).
// Config macro FPU_ARB_RR_EN: defined = round-robin arbitration with pointer
// rr; undefined = fixed priority, lowest valid index wins.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready, req_a/req_b/req_sel/req_rmode : request side
//   resp_valid/resp_ready, resp_y/resp_error/resp_overflow : response side
//   fpu_start, fpu_a/b/sel/round_mode, fpu_y/error/overflow : FPU pins
//   busy (not IDLE), grant_id (current or last grantee)
module fpu_req_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [WORD_W*NREQ-1:0] req_a,
  input  logic [WORD_W*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0]      req_sel,
  input  logic [2*NREQ-1:0]      req_rmode,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [WORD_W-1:0]      resp_y,
  output logic                   resp_error,
  output logic                   resp_overflow,
  output logic                   fpu_start,
  output logic [WORD_W-1:0]      fpu_a,
  output logic [WORD_W-1:0]      fpu_b,
  output logic [1:0]             fpu_sel,
  output logic [1:0]             fpu_round_mode,
  input  logic [WORD_W-1:0]      fpu_y,
  input  logic                   fpu_error,
  input  logic                   fpu_overflow,
  output logic                   busy,
  output logic [GW-1:0]          grant_id
);
  state_t r_state, w_next;

  logic [WORD_W-1:0] r_a, r_b, r_y;
  logic [1:0]        r_sel, r_rmode;
  logic              r_err, r_ovf;
  logic [GW-1:0]     r_gid;

  logic [NREQ-1:0]   w_onehot;
  logic [GW-1:0]     w_idx, w_ptr;
  logic              w_any, w_accept;

  logic [NREQ-1:0][WORD_W-1:0] w_a_arr, w_b_arr;
  logic [NREQ-1:0][1:0]        w_sel_arr, w_rm_arr;

  assign w_a_arr   = req_a;
  assign w_b_arr   = req_b;
  assign w_sel_arr = req_sel;
  assign w_rm_arr  = req_rmode;

`ifdef FPU_ARB_RR_EN
  logic [GW-1:0] r_rr;
  assign w_ptr = r_rr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_rr <= '0;
    else if (w_accept) begin
      if (int'(w_idx) == NREQ - 1)  r_rr <= '0;
      else                          r_rr <= w_idx + 1'b1;
    end
  end
`else
  assign w_ptr = '0;
`endif

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
    .i_valid  (req_valid),
    .i_ptr    (w_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign w_accept = (r_state == IDLE) && w_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = CAPTURE;
      CAPTURE: w_next = RESP;
      RESP:    if (resp_ready[r_gid]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_rmode <= '0;
      r_gid   <= '0;
      r_y     <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= w_a_arr[w_idx];
        r_b     <= w_b_arr[w_idx];
        r_sel   <= w_sel_arr[w_idx];
        r_rmode <= w_rm_arr[w_idx];
        r_gid   <= w_idx;
      end
      if (r_state == CAPTURE) begin
        r_y   <= fpu_y;
        r_err <= fpu_error;
        r_ovf <= fpu_overflow;
      end
    end
  end

  // Gated by reset so the accept strobe drops immediately on reset assertion.
  assign req_ready = (reset && r_state == IDLE) ? w_onehot : '0;

  always_comb begin
    resp_valid = '0;
    if (r_state == RESP) resp_valid[r_gid] = 1'b1;
  end

  assign resp_y         = r_y;
  assign resp_error     = r_err;
  assign resp_overflow  = r_ovf;
  assign fpu_start      = (r_state == ISSUE);
  assign fpu_a          = r_a;
  assign fpu_b          = r_b;
  assign fpu_sel        = r_sel;
  assign fpu_round_mode = r_rmode;
  assign busy           = (r_state != IDLE);
  assign grant_id       = r_gid;
endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Self-checking bench for fpu_req_arbiter (NREQ=4). Follows FPU_ARB_RR_EN
// the same way the RTL does. A cycle-level transaction model checks every
// output on every negedge; directed sequences add literal expectations.
module tb_fpu_req_arbiter;
  import fpu_arb_pkg::*;

  localparam int N  = 4;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic [2*N-1:0]  req_sel = '0, req_rmode = '0;
  logic [31:0]     resp_y, fpu_a, fpu_b, fpu_y;
  logic            resp_error, resp_overflow, fpu_start, busy;
  logic [1:0]      fpu_sel, fpu_round_mode;
  logic            fpu_error, fpu_overflow;
  logic [GW-1:0]   grant_id;

  always #5 clk = ~clk;

  fpu_req_arbiter #(.NREQ(N)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_rmode(req_rmode),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_y(resp_y), .resp_error(resp_error), .resp_overflow(resp_overflow),
    .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_sel(fpu_sel), .fpu_round_mode(fpu_round_mode),
    .fpu_y(fpu_y), .fpu_error(fpu_error), .fpu_overflow(fpu_overflow),
    .busy(busy), .grant_id(grant_id)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // FPU stand-in: exact IEEE results for the directed vectors, a cheap
  // deterministic mix otherwise. Returns {error, overflow, y}.
  function automatic logic [33:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] sel);
    logic [31:0] y;
    logic e, o;
    if (a == 32'h3F800000 && b == 32'h40000000 && sel == OP_ADD)      y = 32'h40400000;
    else if (a == 32'h40000000 && b == 32'h40400000 && sel == OP_MUL) y = 32'h40C00000;
    else y = (a ^ {b[15:0], b[31:16]}) + {30'd0, sel};
    e = (sel == OP_DIV) && (b == 32'd0);
    o = a[30] & b[30] & sel[1];
    return {e, o, y};
  endfunction

  // Registered FPU: result appears the cycle after start, shares the reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) {fpu_error, fpu_overflow, fpu_y} <= '0;
    else if (fpu_start) {fpu_error, fpu_overflow, fpu_y} <= fpu_fn(fpu_a, fpu_b, fpu_sel);
  end

  // ---------------- transaction model + per-cycle compare ----------------
  // age: -1 idle, else cycles since the accept edge (3+ = response pending).
  int          age = -1, m_rr = 0, m_gid = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [1:0]  m_sel = '0, m_rm = '0;
  logic [33:0] m_resp = '0;

  initial begin
    logic [N-1:0] e_rdy, e_rv;
    int w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp", {resp_error, resp_overflow, resp_y}, 0);
        chk("rst_fpu_ops", {fpu_a, fpu_b}, 0);
        chk("rst_ctl", {fpu_start, fpu_sel, fpu_round_mode, busy, grant_id}, 0);
        age = -1; m_rr = 0; m_gid = 0; m_a = '0; m_b = '0;
        m_sel = '0; m_rm = '0; m_resp = '0;
      end else begin
        e_rdy = '0; e_rv = '0; w = -1;
        if (age < 0)
          for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
        if (w >= 0) e_rdy[w] = 1'b1;
        if (age >= 3) e_rv[m_gid] = 1'b1;
        chk("req_ready", req_ready, e_rdy);
        chk("resp_valid", resp_valid, e_rv);
        chk("fpu_start", fpu_start, age == 1);
        chk("busy", busy, age >= 0);
        chk("grant_id", grant_id, m_gid);
        chk("fpu_ops", {fpu_a, fpu_b, fpu_sel, fpu_round_mode}, {m_a, m_b, m_sel, m_rm});
        chk("resp_word", {resp_error, resp_overflow, resp_y}, m_resp);
        // advance to what the coming edge does
        if (age < 0) begin
          if (w >= 0) begin
            m_a = req_a[32*w +: 32]; m_b = req_b[32*w +: 32];
            m_sel = req_sel[2*w +: 2]; m_rm = req_rmode[2*w +: 2];
            m_gid = w;
`ifdef FPU_ARB_RR_EN
            m_rr = (w + 1) % N;
`endif
            age = 1;
          end
        end else if (age == 1) age = 2;
        else if (age == 2) begin
          m_resp = fpu_fn(m_a, m_b, m_sel);
          age = 3;
        end else if (resp_ready[m_gid]) age = -1;
      end
    end
  end

  // Accept monitor: grantee and cycle of every accept.
  int acc_q[$];
  int acc_t[$];
  int cyc = 0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_n)
      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin acc_q.push_back(i); acc_t.push_back(cyc); end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] sel, input logic [1:0] rm);
    req_a[32*i +: 32] = a; req_b[32*i +: 32] = b;
    req_sel[2*i +: 2] = sel; req_rmode[2*i +: 2] = rm;
  endtask

  // One call = `cycles` clocks, entered and left at posedge+1. Valid drops
  // only on accept (or stays up with hold); masked requesters (re)assert.
  task automatic run(input int cycles, input logic [N-1:0] mask, input bit hold,
                     input bit rnd, input bit rresp, input bit chk_y,
                     input logic [31:0] want_y);
    logic [N-1:0] acc;
    repeat (cycles) begin
      @(negedge clk);
      acc = req_ready;
      if (chk_y && resp_valid != 0) chk("dir_resp_y", resp_y, want_y);
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && !(hold && mask[i])) req_valid[i] = 1'b0;
        if (!req_valid[i] && mask[i] && (hold || $urandom_range(0, 2) == 0)) begin
          if (rnd)
            set_op(i, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
          req_valid[i] = 1'b1;
        end
      end
      if (rresp) resp_ready = N'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    resp_ready = '1;
    while ((req_valid != 0 || busy) && n < 300) begin
      run(1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      n++;
    end
    chk("drain_done", (req_valid == 0) && !busy, 1);
  endtask

  initial begin
    int base, exp_id;
    logic [31:0] y0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // All four requesters multiply 2.0*3.0, resp_ready high.
    for (int i = 0; i < N; i++) set_op(i, 32'h40000000, 32'h40400000, OP_MUL, 2'(i));
    resp_ready = '1;
    req_valid  = '1;
    base = acc_q.size();
    run(17, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40C00000);
    chk("mul_grant_count", acc_q.size() >= base + 5, 1);
    if (acc_q.size() >= base + 5)
      for (int k = 0; k < 5; k++) begin
`ifdef FPU_ARB_RR_EN
        exp_id = k % 4;
`else
        exp_id = 0;
`endif
        chk("mul_grant_order", acc_q[base+k], exp_id);
        if (k > 0) chk("mul_spacing", acc_t[base+k] - acc_t[base+k-1], 4);
      end
    drain();

    // Single add on requester 0: exact latency.
    set_op(0, 32'h3F800000, 32'h40000000, OP_ADD, 2'd0);
    req_valid = 4'b0001;
    @(negedge clk); chk("add_accept", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk); chk("add_start", fpu_start, 1); chk("add_fpu_a", fpu_a, 32'h3F800000);
    @(negedge clk); chk("add_capture_rv", resp_valid, 0);
    @(negedge clk); chk("add_resp_valid", resp_valid, 4'b0001);
    chk("add_resp_y", resp_y, 32'h40400000);
    @(posedge clk); #1;
    drain();

    // Wrap: grant to 3, then 1 and 3 valid -> 1 goes next.
    set_op(3, 32'h11, 32'h22, OP_SUB, 2'd1);
    set_op(1, 32'h33, 32'h44, OP_DIV, 2'd2);
    req_valid = 4'b1000;
    drain();
    req_valid = 4'b1010;
    base = acc_q.size();
    drain();
    chk("wrap_count", acc_q.size(), base + 2);
    if (acc_q.size() >= base + 2) begin
      chk("wrap_first", acc_q[base], 1);
      chk("wrap_second", acc_q[base+1], 3);
    end

    // Response stall: 10 cycles of resp_ready low with requester 2 waiting.
    set_op(0, 32'h3F800000, 32'h40000000, OP_ADD, 2'd3);
    set_op(2, 32'h55, 32'h66, OP_ADD, 2'd0);
    resp_ready = '0;
    req_valid  = 4'b0001;
    @(negedge clk); chk("stall_accept", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = 4'b0100;
    repeat (3) @(negedge clk);
    y0 = 32'h40400000;
    for (int k = 0; k < 10; k++) begin
      chk("stall_resp_valid", resp_valid, 4'b0001);
      chk("stall_resp_y", resp_y, y0);
      chk("stall_no_ready", req_ready, 0);
      chk("stall_no_start", fpu_start, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    drain();

    // Reset during CAPTURE of a grant to 1, with 0 and 2 pending.
    set_op(1, 32'hAAAA5555, 32'h12345678, OP_MUL, 2'd2);
    set_op(0, 32'h01, 32'h02, OP_SUB, 2'd1);
    req_valid = 4'b0010;
    @(negedge clk); chk("rst_seq_accept", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid = 4'b0101;          // now ISSUE
    @(posedge clk); #2 rst_n = 1'b0;                 // now CAPTURE
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_fpu_a", fpu_a, 0);
    chk("midrst_grant", grant_id, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("post_rst_grant", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    drain();

`ifndef FPU_ARB_RR_EN
    // Fixed priority: 2 and 3 always valid -> 2 wins every time.
    set_op(2, 32'h40000000, 32'h40400000, OP_MUL, 2'd0);
    set_op(3, 32'h40000000, 32'h40400000, OP_MUL, 2'd0);
    req_valid = 4'b1100;
    base = acc_q.size();
    run(13, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40C00000);
    chk("fixed_count", acc_q.size() >= base + 4, 1);
    if (acc_q.size() >= base + 4)
      for (int k = 0; k < 4; k++) chk("fixed_grant", acc_q[base+k], 2);
    req_valid[2] = 1'b0;
    drain();
`endif

    // Random traffic with random back-pressure.
    base = acc_q.size();
    run(3000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    drain();
    chk("random_activity", acc_q.size() - base > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
